// File: rtl/shared_accum_arbiter.sv
// shared_accum_arbiter
//   Two requesters share one accumulator. A round-robin arbiter hands out
//   bursts of BURST additions. The owner's addends are summed into Q modulo
//   2^WIDTH. DONE pulses for one cycle when a burst completes. If the owner
//   drops its request mid-burst, the burst aborts and Q keeps the partial sum.
//
//   Optional feature: define ACCUM_OVF_DETECT_EN to build sticky carry-out
//   detection on OVF. Without it, OVF is tied low and no carry logic exists.
//
// Ports
//   C          clock, rising edge
//   CLR        asynchronous active-high reset
//   REQ0/REQ1  level-held access requests
//   D0/D1      addends, used only while the corresponding requester owns the burst
//   GNT0/GNT1  registered grants (mutually exclusive)
//   Q          accumulator value
//   DONE       one-cycle burst-complete pulse
//   OVF        sticky carry-out of the current/last burst
module shared_accum_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] Q,
  output logic             DONE,
  output logic             OVF
);

  // Wide enough for the largest legal BURST (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done_q, done_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;

  logic             win;
  logic             own_req;
  logic [WIDTH-1:0] own_data;

`ifdef ACCUM_OVF_DETECT_EN
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
`else
  logic [WIDTH-1:0] sum;
`endif

  // Round-robin: on contention the requester that was not served last wins.
  assign win      = (REQ0 && REQ1) ? ~last_q : REQ1;
  assign own_req  = owner_q ? REQ1 : REQ0;
  assign own_data = owner_q ? D1 : D0;

`ifdef ACCUM_OVF_DETECT_EN
  assign sum = {1'b0, acc_q} + {1'b0, own_data};
`else
  assign sum = acc_q + own_data;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done_d  = 1'b0;
    last_d  = last_q;
    owner_d = owner_q;
`ifdef ACCUM_OVF_DETECT_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          state_d = S_BUSY;
          owner_d = win;
          acc_d   = '0;
          cnt_d   = '0;
          gnt0_d  = ~win;
          gnt1_d  = win;
`ifdef ACCUM_OVF_DETECT_EN
          ovf_d   = 1'b0;
`endif
        end
      end

      S_BUSY: begin
        if (own_req) begin
          acc_d = sum[WIDTH-1:0];
          cnt_d = cnt_q + CNT_W'(1);
`ifdef ACCUM_OVF_DETECT_EN
          ovf_d = ovf_q | sum[WIDTH];
`endif
          // This edge performs the final addition of the burst.
          if (cnt_q == CNT_W'(BURST - 1)) begin
            state_d = S_DONE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done_d  = 1'b1;
            last_d  = owner_q;
          end
        end else begin
          // Owner released early: abort, keep the partial sum.
          state_d = S_IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          last_d  = owner_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; LAST resets to 1 so requester 0 wins first.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
`ifdef ACCUM_OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done_q  <= done_d;
      last_q  <= last_d;
      owner_q <= owner_d;
`ifdef ACCUM_OVF_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign Q    = acc_q;
  assign DONE = done_q;
`ifdef ACCUM_OVF_DETECT_EN
  assign OVF  = ovf_q;
`else
  assign OVF  = 1'b0;
`endif

endmodule
